fifo_pkt_wr_arb: RTL and testbench

FIFO_PKT_WR_ARB -- requirements
Module: fifo_pkt_wr_arb

---
 rtl/fifo_ctrl_pkg.sv | 13 +
 rtl/fifo_pkt_wr_arb_rr_pick.sv | 32 +++
 rtl/fifo_pkt_wr_arb.sv | 109 ++++++++++
 tb/tb_fifo_pkt_wr_arb.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the packet-write arbiter in front of the 128-bit FIFO.
package fifo_ctrl_pkg;

    localparam int DEF_DW     = 128;
    localparam int DEF_CNT_W  = 9;
    localparam int PKT_CNT_W  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_pkt_wr_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or after the start pointer.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   start,
    output logic         found,
    output logic [2:0]   index
);

    logic [2*N-1:0] rotated;
    logic [3:0]     pos;

    // Rotating a doubled copy puts the request at the start pointer into bit 0.
    always_comb begin
        found   = 1'b0;
        index   = '0;
        pos     = '0;
        rotated = {req, req} >> start;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, start} + 4'(k);
            if (pos >= 4'(N)) begin
                pos = pos - 4'(N);
            end
            if (!found && rotated[k]) begin
                found = 1'b1;
                index = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/fifo_pkt_wr_arb.sv
// Packet-atomic write arbiter: locks one requester per packet and streams its beats into the FIFO.
module fifo_pkt_wr_arb
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int DW           = DEF_DW,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int AFULL_THRESH = 240
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    in_valid,
    input  logic [NUM_PORTS-1:0]    in_last,
    input  logic [NUM_PORTS*DW-1:0] in_data,
    output logic [NUM_PORTS-1:0]    in_ready,
    output logic [DW-1:0]           fifo_din,
    output logic                    fifo_wr_en,
    input  logic                    fifo_full,
    input  logic [CNT_W-1:0]        fifo_data_count,
    output logic [2:0]              grant_id,
    output logic                    busy,
    output logic [PKT_CNT_W-1:0]    pkt_count
);

    localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(AFULL_THRESH);
    localparam logic [2:0]       LAST_IDX  = 3'(NUM_PORTS - 1);

    arb_state_t state, next_state;
    logic [2:0] rr_ptr;
    logic       pick_found;
    logic [2:0] pick_idx;
    logic       g_valid;
    logic       g_last;
    logic       eop;

    rr_pick #(.N(NUM_PORTS)) u_rr_pick (
        .req   (in_valid),
        .start (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    // Granted port's beat is a pure mux so the write path has no added latency.
    always_comb begin
        fifo_din = '0;
        g_valid  = 1'b0;
        g_last   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_id == 3'(i)) begin
                fifo_din = in_data[i*DW +: DW];
                g_valid  = in_valid[i];
                g_last   = in_last[i];
            end
        end
    end

    assign busy = (state == PKT) && !rst;

    // Almost-full only gates the start of a packet; mid-packet only fifo_full stalls.
    always_comb begin
        next_state = state;
        in_ready   = '0;
        fifo_wr_en = 1'b0;
        eop        = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found && (fifo_data_count < AFULL_LVL)) begin
                    next_state = PKT;
                end
            end
            PKT: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    in_ready[i] = (grant_id == 3'(i)) && !fifo_full;
                end
                fifo_wr_en = g_valid && !fifo_full;
                if (fifo_wr_en && g_last) begin
                    eop        = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (rst) begin
            in_ready   = '0;
            fifo_wr_en = 1'b0;
            eop        = 1'b0;
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            pkt_count <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == PKT) begin
                grant_id <= pick_idx;
            end
            if (eop) begin
                rr_ptr    <= (grant_id == LAST_IDX) ? 3'd0 : grant_id + 3'd1;
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_pkt_wr_arb.sv
// Directed self-checking bench for fifo_pkt_wr_arb with hand-computed expectations.
module tb_fifo_pkt_wr_arb;

    localparam int NP = 4;
    localparam int DW = 128;

    logic            clk;
    logic            rst;
    logic [NP-1:0]   in_valid;
    logic [NP-1:0]   in_last;
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]   in_ready;
    logic [DW-1:0]   fifo_din;
    logic            fifo_wr_en;
    logic            fifo_full;
    logic [8:0]      fifo_data_count;
    logic [2:0]      grant_id;
    logic            busy;
    logic [15:0]     pkt_count;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int stalls = 0;

    fifo_pkt_wr_arb #(
        .NUM_PORTS    (NP),
        .DW           (DW),
        .CNT_W        (9),
        .AFULL_THRESH (240)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_last         (in_last),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .fifo_din        (fifo_din),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_full       (fifo_full),
        .fifo_data_count (fifo_data_count),
        .grant_id        (grant_id),
        .busy            (busy),
        .pkt_count       (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] expData(input int p, input logic [7:0] tag);
        return {112'h0, 8'(p), tag};
    endfunction

    // Drive one cycle's inputs on the falling edge; outputs are sampled 1 ns later.
    task automatic applyStimulus(input logic r, input logic [NP-1:0] v, input logic [NP-1:0] l,
                                 input logic f, input logic [8:0] cnt, input logic [7:0] tag);
        @(negedge clk);
        rst             = r;
        in_valid        = v;
        in_last         = l;
        fifo_full       = f;
        fifo_data_count = cnt;
        for (int i = 0; i < NP; i++) begin
            in_data[i*DW +: DW] = expData(i, tag);
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst             = 1'b1;
        in_valid        = '1;
        in_last         = '0;
        in_data         = '0;
        fifo_full       = 1'b0;
        fifo_data_count = '0;

        // Reset held two cycles with every port requesting
        applyStimulus(1'b1, 4'hF, 4'h0, 1'b0, 9'd0, 8'h00);
        applyStimulus(1'b1, 4'hF, 4'h0, 1'b0, 9'd0, 8'h00);
        checkOutput("rst_wr_en", fifo_wr_en, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pkt_count", pkt_count, 0);
        checkOutput("rst_grant_id", grant_id, 0);

        // Round robin over four 2-beat packets: 12 cycles, 8 writes
        for (int p = 0; p < NP; p++) begin
            applyStimulus(1'b0, 4'hF, 4'h0, 1'b0, 9'd0, 8'h10);
            writes += int'(fifo_wr_en);
            checkOutput($sformatf("rr%0d_idle_busy", p), busy, 0);
            applyStimulus(1'b0, 4'hF, 4'h0, 1'b0, 9'd0, 8'hA0);
            writes += int'(fifo_wr_en);
            checkOutput($sformatf("rr%0d_grant", p), grant_id, p);
            checkOutput($sformatf("rr%0d_din0", p), fifo_din, expData(p, 8'hA0));
            applyStimulus(1'b0, 4'hF, 4'(1 << p), 1'b0, 9'd0, 8'hA1);
            writes += int'(fifo_wr_en);
            checkOutput($sformatf("rr%0d_din1", p), fifo_din, expData(p, 8'hA1));
        end
        checkOutput("rr_writes", writes, 8);
        applyStimulus(1'b0, 4'hF, 4'h0, 1'b0, 9'd0, 8'h10);
        checkOutput("rr_pkt_count", pkt_count, 4);
        checkOutput("rr_idle_wr", fifo_wr_en, 0);

        // Wrap back to port 0, then backpressure for three cycles mid-packet
        writes = 0;
        applyStimulus(1'b0, 4'hF, 4'h0, 1'b0, 9'd0, 8'hB0);
        writes += int'(fifo_wr_en);
        checkOutput("rr_wrap_grant", grant_id, 0);
        checkOutput("bp_din0", fifo_din, expData(0, 8'hB0));
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 4'hF, 4'h0, 1'b1, 9'd0, 8'hB1);
            writes += int'(fifo_wr_en);
            stalls += int'(busy && !fifo_wr_en);
            checkOutput($sformatf("bp_stall%0d_ready", s), in_ready, 0);
            checkOutput($sformatf("bp_stall%0d_grant", s), grant_id, 0);
        end
        applyStimulus(1'b0, 4'hF, 4'h1, 1'b0, 9'd0, 8'hB1);
        writes += int'(fifo_wr_en);
        checkOutput("bp_din1", fifo_din, expData(0, 8'hB1));
        checkOutput("bp_stalls", stalls, 3);
        checkOutput("bp_writes", writes, 2);

        // Almost-full blocks a new grant until the count drops below threshold
        applyStimulus(1'b0, 4'h4, 4'h0, 1'b0, 9'd240, 8'h20);
        checkOutput("af_pkt_count", pkt_count, 5);
        checkOutput("af_busy0", busy, 0);
        applyStimulus(1'b0, 4'h4, 4'h0, 1'b0, 9'd240, 8'h20);
        checkOutput("af_busy1", busy, 0);
        checkOutput("af_grant_hold", grant_id, 0);
        applyStimulus(1'b0, 4'h4, 4'h0, 1'b0, 9'd239, 8'h20);
        checkOutput("af_busy2", busy, 0);
        applyStimulus(1'b0, 4'h4, 4'h4, 1'b0, 9'd250, 8'hC0);
        checkOutput("af_grant", grant_id, 2);
        checkOutput("af_midpkt_wr", fifo_wr_en, 1);
        checkOutput("af_din", fifo_din, expData(2, 8'hC0));

        // Lock: port 1 goes quiet mid-packet while port 3 requests
        applyStimulus(1'b0, 4'h2, 4'h0, 1'b0, 9'd0, 8'h30);
        checkOutput("lk_idle_busy", busy, 0);
        applyStimulus(1'b0, 4'h2, 4'h0, 1'b0, 9'd0, 8'hD0);
        checkOutput("lk_grant", grant_id, 1);
        checkOutput("lk_wr0", fifo_wr_en, 1);
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b0, 4'h8, 4'h8, 1'b0, 9'd0, 8'hDD);
            checkOutput($sformatf("lk_gap%0d_wr", s), fifo_wr_en, 0);
            checkOutput($sformatf("lk_gap%0d_ready", s), in_ready, 4'h2);
            checkOutput($sformatf("lk_gap%0d_grant", s), grant_id, 1);
        end
        applyStimulus(1'b0, 4'hA, 4'h2, 1'b0, 9'd0, 8'hD1);
        checkOutput("lk_din1", fifo_din, expData(1, 8'hD1));
        checkOutput("lk_wr1", fifo_wr_en, 1);
        applyStimulus(1'b0, 4'hA, 4'h0, 1'b0, 9'd0, 8'h30);
        checkOutput("lk_pkt_count", pkt_count, 7);

        // rr_ptr = 2 makes port 3 win over port 1; reset after its second beat
        applyStimulus(1'b0, 4'hA, 4'h0, 1'b0, 9'd0, 8'hE0);
        checkOutput("lk_next_grant", grant_id, 3);
        checkOutput("mr_din0", fifo_din, expData(3, 8'hE0));
        applyStimulus(1'b0, 4'hA, 4'h0, 1'b0, 9'd0, 8'hE1);
        checkOutput("mr_wr1", fifo_wr_en, 1);
        applyStimulus(1'b1, 4'hA, 4'h0, 1'b0, 9'd0, 8'hE2);
        checkOutput("mr_rst_wr", fifo_wr_en, 0);
        checkOutput("mr_rst_ready", in_ready, 0);
        checkOutput("mr_rst_busy", busy, 0);
        applyStimulus(1'b0, 4'hA, 4'h0, 1'b0, 9'd0, 8'h40);
        checkOutput("mr_idle_busy", busy, 0);
        checkOutput("mr_grant_clr", grant_id, 0);
        checkOutput("mr_pkt_count", pkt_count, 0);
        applyStimulus(1'b0, 4'hA, 4'h0, 1'b0, 9'd0, 8'h41);
        checkOutput("mr_next_grant", grant_id, 1);
        checkOutput("mr_next_busy", busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
